// File: rtl/fft_leaves_sched_pkg.sv
// ----------------------------------------------------------------------------
// fft_leaves_sched_pkg
// Shared definitions for the leaf-level scheduler of the additive FFT:
//   - state_e      : scheduler FSM states
//   - DATA_W       : GF(2^8) coefficient width
//   - LEAF_SIZE    : coefficients produced per leaf group
//   - LEAF_K_W     : width of the per-group output index k
//   - GROUP_PERIOD : cycles spent per leaf group (READ, LOAD, START,
//                    4 init cycles, 16 output beats)
// ----------------------------------------------------------------------------
package fft_leaves_sched_pkg;

    localparam int DATA_W       = 8;
    localparam int LEAF_SIZE    = 16;
    localparam int LEAF_K_W     = $clog2(LEAF_SIZE);
    localparam int GROUP_PERIOD = 23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fft_leaves_sched_if.sv
// ----------------------------------------------------------------------------
// fft_leaves_sched_if
// Bundles the three buses of the leaf scheduler:
//   - coefficient memory read : rd_en_o, rd_addr_o, rd_data_i ({a1,a0})
//   - leaf butterfly          : bf_start_o, bf_a0_o, bf_a1_o,
//                               bf_busy_i, bf_dout_i, bf_dout_valid_i
//   - output memory write     : wr_en_o, wr_addr_o ({group,k}), wr_data_o
// The _o/_i suffixes are seen from the scheduler; the scheduler uses the
// master modport, memories/butterfly (or a bench) the slave modport.
// ----------------------------------------------------------------------------
interface fft_leaves_sched_if
    import fft_leaves_sched_pkg::*;
#(
    parameter int GRP_W  = 4,
    parameter int DATA_W = fft_leaves_sched_pkg::DATA_W
);

    logic                       rd_en_o;
    logic [GRP_W-1:0]           rd_addr_o;
    logic [2*DATA_W-1:0]        rd_data_i;

    logic                       bf_start_o;
    logic [DATA_W-1:0]          bf_a0_o;
    logic [DATA_W-1:0]          bf_a1_o;
    logic                       bf_busy_i;
    logic [DATA_W-1:0]          bf_dout_i;
    logic                       bf_dout_valid_i;

    logic                       wr_en_o;
    logic [GRP_W+LEAF_K_W-1:0]  wr_addr_o;
    logic [DATA_W-1:0]          wr_data_o;

    modport master (
        output rd_en_o, rd_addr_o,
        input  rd_data_i,
        output bf_start_o, bf_a0_o, bf_a1_o,
        input  bf_busy_i, bf_dout_i, bf_dout_valid_i,
        output wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  rd_en_o, rd_addr_o,
        output rd_data_i,
        input  bf_start_o, bf_a0_o, bf_a1_o,
        output bf_busy_i, bf_dout_i, bf_dout_valid_i,
        input  wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/fft_leaves_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_leaves_addr_gen
// Group and output-index counters of the leaf scheduler.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : return both counters to 0 (new run or aborted run)
//   beat_i         : one butterfly output beat written; advance k
//   next_grp_i     : leaving WAIT; advance the group index
//   grp_o          : current group (also the coefficient read address)
//   k_o            : index of the next output beat within the group
//   last_grp_o     : current group is the final one of the run
//   wr_addr_o      : {group, k} output memory address
// ----------------------------------------------------------------------------
module fft_leaves_addr_gen
    import fft_leaves_sched_pkg::*;
#(
    parameter int NUM_GROUPS = 16,
    parameter int GRP_W      = $clog2(NUM_GROUPS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      beat_i,
    input  logic                      next_grp_i,
    output logic [GRP_W-1:0]          grp_o,
    output logic [LEAF_K_W-1:0]       k_o,
    output logic                      last_grp_o,
    output logic [GRP_W+LEAF_K_W-1:0] wr_addr_o
);

    localparam logic [GRP_W-1:0]    GRP_LAST = GRP_W'(NUM_GROUPS - 1);
    localparam logic [LEAF_K_W-1:0] K_LAST   = LEAF_K_W'(LEAF_SIZE - 1);

    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [LEAF_K_W-1:0] k_q, k_d;

    // Both counters wrap explicitly so a GRP_W wider than needed still
    // returns to group 0 after the last group.
    always_comb begin
        grp_d = grp_q;
        k_d   = k_q;
        if (clear_i) begin
            grp_d = '0;
            k_d   = '0;
        end else begin
            if (beat_i) begin
                k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end
            if (next_grp_i) begin
                grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grp_q <= '0;
            k_q   <= '0;
        end else begin
            grp_q <= grp_d;
            k_q   <= k_d;
        end
    end

    assign grp_o      = grp_q;
    assign k_o        = k_q;
    assign last_grp_o = (grp_q == GRP_LAST);
    assign wr_addr_o  = {grp_q, k_q};

endmodule

// File: rtl/fft_leaves_sched.sv
// ----------------------------------------------------------------------------
// fft_leaves_sched
// Walks NUM_GROUPS leaf groups of the additive FFT: for each group it reads
// the {a1,a0} coefficient pair, hands it to an external leaf butterfly,
// and streams the 16 resulting coefficients into the output memory.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : one-cycle run request (ignored while busy or in DONE)
//   busy_o        : run in progress
//   done_o        : one-cycle pulse when all groups completed normally
//   err_o         : sticky protocol error, cleared by the next accepted start
//   bus           : memory read / butterfly / memory write buses
// ----------------------------------------------------------------------------
module fft_leaves_sched
    import fft_leaves_sched_pkg::*;
#(
    parameter int NUM_GROUPS = 16,
    parameter int GRP_W      = $clog2(NUM_GROUPS),
    parameter int DATA_W     = fft_leaves_sched_pkg::DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    fft_leaves_sched_if.master    bus
);

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                rdEn_q;
    logic                bfStart_q;
    logic [DATA_W-1:0]   opA0_q;
    logic [DATA_W-1:0]   opA1_q;

    logic [GRP_W-1:0]          grp;
    logic [LEAF_K_W-1:0]       k;
    logic                      lastGrp;
    logic [GRP_W+LEAF_K_W-1:0] wrAddr;

    logic beat;
    logic lastBeat;
    logic errWait;
    logic errStray;
    logic errHit;
    logic startAcc;

    // A beat is only legal in WAIT. The butterfly going idle mid-group
    // (k already advanced, nothing valid) means beats were lost.
    assign beat     = (state_q == ST_WAIT) && bus.bf_dout_valid_i;
    assign lastBeat = beat && (k == LEAF_K_W'(LEAF_SIZE - 1));
    assign errWait  = (state_q == ST_WAIT) && !bus.bf_busy_i
                      && !bus.bf_dout_valid_i && (k != '0);
    assign errStray = bus.bf_dout_valid_i && (state_q != ST_WAIT);
    assign errHit   = errWait || errStray;
    assign startAcc = (state_q == ST_IDLE) && start_i && !errHit;

    fft_leaves_addr_gen #(
        .NUM_GROUPS (NUM_GROUPS),
        .GRP_W      (GRP_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (startAcc || errHit),
        .beat_i     (beat),
        .next_grp_i (lastBeat),
        .grp_o      (grp),
        .k_o        (k),
        .last_grp_o (lastGrp),
        .wr_addr_o  (wrAddr)
    );

    // Pulsed outputs default low each cycle and are raised on the
    // transition into the state that owns them. An error overrides any
    // transition, so a start coincident with a stray beat is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdEn_q    <= 1'b0;
            bfStart_q <= 1'b0;
            opA0_q    <= '0;
            opA1_q    <= '0;
        end else begin
            done_q    <= 1'b0;
            rdEn_q    <= 1'b0;
            bfStart_q <= 1'b0;
            if (errHit) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            rdEn_q  <= 1'b1;
                            state_q <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        opA1_q    <= bus.rd_data_i[2*DATA_W-1:DATA_W];
                        opA0_q    <= bus.rd_data_i[DATA_W-1:0];
                        bfStart_q <= 1'b1;
                        state_q   <= ST_START;
                    end
                    ST_START: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (lastBeat) begin
                            if (lastGrp) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                rdEn_q  <= 1'b1;
                                state_q <= ST_READ;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign bus.rd_en_o    = rdEn_q;
    assign bus.rd_addr_o  = grp;
    assign bus.bf_start_o = bfStart_q;
    assign bus.bf_a0_o    = opA0_q;
    assign bus.bf_a1_o    = opA1_q;
    // Output writes follow the butterfly beat with no register stage.
    assign bus.wr_en_o    = beat;
    assign bus.wr_addr_o  = wrAddr;
    assign bus.wr_data_o  = beat ? bus.bf_dout_i : '0;

endmodule

// File: tb/tb_fft_leaves_sched.sv
// ----------------------------------------------------------------------------
// tb_fft_leaves_sched
// Directed bench for fft_leaves_sched with NUM_GROUPS=4: coefficient memory
// model, behavioural leaf butterfly (evaluates a0 + a1*span(k) over the
// basis {08,54,9d,4e}), write/done monitor and a linear stimulus sequence.
// ----------------------------------------------------------------------------
module tb_fft_leaves_sched;

    localparam int NG = 4;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic err;

    fft_leaves_sched_if #(.GRP_W(GW), .DATA_W(8)) bus ();

    fft_leaves_sched #(.NUM_GROUPS(NG)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;
    int c0          = 0;
    int d0          = 0;

    logic [15:0] mem [NG];
    // Hand-computed XOR spans of {08,54,9d,4e} selected by the bits of k.
    logic [7:0]  spanTab [16] = '{8'h00, 8'h08, 8'h54, 8'h5c, 8'h9d, 8'h95, 8'hc9, 8'hc1,
                                  8'h4e, 8'h46, 8'h1a, 8'h12, 8'hd3, 8'hdb, 8'h87, 8'h8f};

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] spanOf(input logic [3:0] kk);
        logic [7:0] s;
        s = 8'h00;
        if (kk[0]) s = s ^ 8'h08;
        if (kk[1]) s = s ^ 8'h54;
        if (kk[2]) s = s ^ 8'h9d;
        if (kk[3]) s = s ^ 8'h4e;
        return s;
    endfunction

    // Expected output for the operand pairs used here (a1 is 00 or 01).
    function automatic logic [7:0] expData(input int g, input int kk);
        logic [15:0] w;
        w = mem[g];
        if (w[15:8] == 8'h00) return w[7:0];
        return w[7:0] ^ spanTab[kk];
    endfunction

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(posedge clk) bus.rd_data_i <= bus.rd_en_o ? mem[bus.rd_addr_o] : 16'h0000;

    // Behavioural butterfly: 4 init cycles then 16 valid beats.
    logic [4:0] bfCnt;
    logic       dropMode   = 1'b0;
    logic       forceValid = 1'b0;
    logic       cut;
    logic       inValid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bfCnt <= 5'd0;
        else if (bus.bf_start_o) bfCnt <= 5'd1;
        else if (bfCnt == 5'd20 || (dropMode && bfCnt == 5'd12)) bfCnt <= 5'd0;
        else if (bfCnt != 5'd0) bfCnt <= bfCnt + 5'd1;
    end

    assign cut                 = dropMode && (bfCnt >= 5'd12);
    assign inValid             = (bfCnt >= 5'd5) && (bfCnt <= 5'd20) && !cut;
    assign bus.bf_busy_i       = (bfCnt != 5'd0) && !cut;
    assign bus.bf_dout_valid_i = inValid || forceValid;
    assign bus.bf_dout_i       = forceValid ? 8'haa :
                                 (inValid ? (bus.bf_a0_o ^ gfMul(bus.bf_a1_o, spanOf(4'(bfCnt - 5'd5))))
                                          : 8'h00);

    int         wrCount   = 0;
    int         doneCount = 0;
    int         doneCycle = 0;
    logic [5:0] wrAddrLog [64];
    logic [7:0] wrDataLog [64];
    int         wrTimeLog [64];
    int         rdTimeLog [NG];

    always @(negedge clk) begin
        if (!rst_n) begin
            wrCount <= 0;
        end else begin
            if (bus.rd_en_o) begin
                rdTimeLog[bus.rd_addr_o] <= cycleCnt - c0;
                if (bus.rd_addr_o == '0) wrCount <= 0;
            end
            if (bus.wr_en_o && wrCount < 64) begin
                wrAddrLog[wrCount[5:0]] <= bus.wr_addr_o;
                wrDataLog[wrCount[5:0]] <= bus.wr_data_o;
                wrTimeLog[wrCount[5:0]] <= cycleCnt - c0;
                wrCount <= wrCount + 1;
            end
            if (done) begin
                doneCount <= doneCount + 1;
                doneCycle <= cycleCnt - c0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Cycle 0 is the cycle in which start is sampled; returns at cycle 1.
    task automatic applyStimulus();
        @(negedge clk);
        c0    = cycleCnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic advanceTo(input int n);
        while (cycleCnt - c0 < n) @(negedge clk);
    endtask

    task automatic waitEnd(input int budget);
        int n;
        n = 0;
        while (!done && !err && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic verifyRun(input int nWr, input int nRd);
        checkOutput("wr_count", wrCount, nWr);
        for (int g = 0; g < nRd; g++) begin
            checkOutput("rd_time", rdTimeLog[g], 1 + 23 * g);
        end
        for (int i = 0; i < nWr && i < 64; i++) begin
            checkOutput("wr_addr", {26'd0, wrAddrLog[i]}, i);
            checkOutput("wr_data", {24'd0, wrDataLog[i]}, {24'd0, expData(i / 16, i % 16)});
            checkOutput("wr_time", wrTimeLog[i], 8 + 23 * (i / 16) + (i % 16));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int g = 0; g < NG; g++) mem[g] = 16'(g + 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_state",
                    {2'b00, busy, done, err, bus.rd_en_o, bus.bf_start_o, bus.wr_en_o,
                     bus.rd_addr_o, bus.wr_addr_o, bus.bf_a0_o, bus.bf_a1_o}, 32'd0);

        // Plain run over four groups.
        d0 = doneCount;
        applyStimulus();
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        waitEnd(150);
        checkOutput("done_cycle", doneCycle, 93);
        checkOutput("done_count", doneCount - d0, 1);
        verifyRun(64, NG);
        checkOutput("idle_after_done", {30'd0, busy, err}, 32'd0);

        // Group 0 evaluates the basis spans; start pulsed mid-run.
        mem[0] = 16'h0100;
        d0 = doneCount;
        applyStimulus();
        advanceTo(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_ignores_start", {31'd0, busy}, 32'd1);
        waitEnd(150);
        checkOutput("pulse_done_cycle", doneCycle, 93);
        checkOutput("pulse_done_count", doneCount - d0, 1);
        verifyRun(64, NG);
        mem[0] = 16'h0001;

        // Asynchronous reset in the middle of group 1, then restart.
        applyStimulus();
        advanceTo(40);
        checkOutput("pre_reset_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", {26'd0, busy, bus.wr_en_o, bus.bf_start_o, bus.rd_en_o, done, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = doneCount;
        applyStimulus();
        checkOutput("restart_read", {29'd0, bus.rd_en_o, bus.rd_addr_o}, {29'd0, 1'b1, 2'd0});
        waitEnd(150);
        checkOutput("restart_done_cycle", doneCycle, 93);
        checkOutput("restart_done_count", doneCount - d0, 1);
        verifyRun(64, NG);

        // Butterfly stops after 7 beats.
        dropMode = 1'b1;
        d0 = doneCount;
        applyStimulus();
        waitEnd(150);
        checkOutput("drop_err", {31'd0, err}, 32'd1);
        checkOutput("drop_busy", {31'd0, busy}, 32'd0);
        checkOutput("drop_no_done", doneCount - d0, 0);
        verifyRun(7, 1);
        dropMode = 1'b0;

        // Next start clears the error and runs normally.
        d0 = doneCount;
        applyStimulus();
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        waitEnd(150);
        checkOutput("clear_done_cycle", doneCycle, 93);
        checkOutput("clear_done_count", doneCount - d0, 1);
        verifyRun(64, NG);

        // Stray beat in IDLE together with start: error wins, start dropped.
        @(negedge clk);
        forceValid = 1'b1;
        start      = 1'b1;
        #1 checkOutput("stray_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
        @(negedge clk);
        forceValid = 1'b0;
        start      = 1'b0;
        checkOutput("stray_err", {29'd0, err, busy, bus.rd_en_o}, 32'b100);
        applyStimulus();
        checkOutput("stray_recover", {30'd0, err, busy}, 32'b01);
        waitEnd(150);
        checkOutput("stray_done_cycle", doneCycle, 93);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
